fifo_serial_drain: RTL and testbench

//  Downstream consumer of the 16-bit synchronous FIFO. Pops one word at a time
//  via readp/emptyp and captures it from the FIFO's registered dout.

---
 rtl/fifo_serial_drain.sv | 164 ++++++++++++++++
 tb/tb_fifo_serial_drain.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_serial_drain.sv
// fifo_serial_drain: pops words from a synchronous FIFO and sends each one as a
// serial frame (start, LSB-first data, optional even parity, stop). Rev 1.0
`default_nettype none

module fifo_serial_drain #(
  parameter int WIDTH      = 16,
  parameter int BIT_CYCLES = 4,
  parameter int PARITY_EN  = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             emptyp,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             readp,
  output logic             sout,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      word_count
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    PAR   = 3'd5,
    STOP  = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic             sout_q, sout_d;
  logic [15:0]      word_count_q, word_count_d;
  logic             bit_end;

  assign bit_end = (cyc_q == CW'(BIT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cyc_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      sout_q       <= 1'b1;
      word_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      sout_q       <= sout_d;
      word_count_q <= word_count_d;
    end
  end

  // sout_d is the value of the bit being entered, so sout changes on the edge
  // that starts each bit; the shift register always holds the bits still to send.
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_d        = par_q;
    sout_d       = sout_q;
    word_count_d = word_count_q;

    case (state_q)
      IDLE: begin
        sout_d = 1'b1;
        if (enable && !emptyp) state_d = POP;
      end

      POP: state_d = LOAD;

      LOAD: begin
        shift_d = fifo_dout;
        par_d   = 1'b0;
        cyc_d   = '0;
        bit_d   = '0;
        sout_d  = 1'b0;
        state_d = START;
      end

      START: begin
        if (bit_end) begin
          cyc_d   = '0;
          bit_d   = '0;
          sout_d  = shift_q[0];
          par_d   = par_q ^ shift_q[0];
          shift_d = shift_q >> 1;
          state_d = DATA;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_q == BW'(WIDTH - 1)) begin
            if (PARITY_EN != 0) begin
              sout_d  = par_q;
              state_d = PAR;
            end else begin
              sout_d  = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            sout_d  = shift_q[0];
            par_d   = par_q ^ shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      PAR: begin
        if (bit_end) begin
          cyc_d   = '0;
          sout_d  = 1'b1;
          state_d = STOP;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          cyc_d        = '0;
          word_count_d = word_count_q + 16'd1;
          state_d      = (enable && !emptyp) ? POP : IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      default: begin
        sout_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign readp      = (state_q == POP);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == STOP) && bit_end;
  assign sout       = sout_q;
  assign word_count = word_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_serial_drain.sv
// Scoreboard bench for fifo_serial_drain: a FIFO model feeds the DUT, monitors
// decode each serial frame and compare it with queued expectations.
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_serial_drain;

  localparam int BC = 2;

  typedef struct {
    logic [15:0] d;
    logic        p;
    int          gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable_a = 1'b0;
  logic        emptyp_a;
  logic [15:0] fifo_dout_a = 16'h0;
  logic        readp_a, sout_a, busy_a, frame_done_a;
  logic [15:0] word_count_a;

  logic        enable_b = 1'b1;
  logic        emptyp_b = 1'b1;
  logic [15:0] fifo_dout_b = 16'h0001;
  logic        readp_b, sout_b, busy_b, frame_done_b;
  logic [15:0] word_count_b;

  logic [15:0] fq[$];
  int          fcount = 0;
  exp_t        qa[$];
  exp_t        qb[$];
  logic [15:0] exp_wc_a = 16'd0;
  int          rp_a = 0;
  int          errors = 0;
  int          checks = 0;

  assign emptyp_a = (fcount == 0);

  always #5 clk = ~clk;

  fifo_serial_drain #(.WIDTH(16), .BIT_CYCLES(BC), .PARITY_EN(1)) dut_a (
    .clk(clk), .rstn(rstn), .enable(enable_a), .emptyp(emptyp_a),
    .fifo_dout(fifo_dout_a), .readp(readp_a), .sout(sout_a), .busy(busy_a),
    .frame_done(frame_done_a), .word_count(word_count_a)
  );

  fifo_serial_drain #(.WIDTH(16), .BIT_CYCLES(BC), .PARITY_EN(0)) dut_b (
    .clk(clk), .rstn(rstn), .enable(enable_b), .emptyp(emptyp_b),
    .fifo_dout(fifo_dout_b), .readp(readp_b), .sout(sout_b), .busy(busy_b),
    .frame_done(frame_done_b), .word_count(word_count_b)
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model with registered read data
  always @(posedge clk) begin
    logic [15:0] w;
    if (rstn && readp_a) begin
      if (fcount == 0) begin
        chk("readp_on_empty", 1, 0);
      end else begin
        w = fq.pop_front();
        fcount = fcount - 1;
        fifo_dout_a <= w;
      end
    end
  end

  always @(negedge clk) if (readp_a) rp_a++;

  task automatic push_a(input logic [15:0] d, input logic p, input int gap);
    exp_t e;
    e.d = d; e.p = p; e.gap = gap;
    fq.push_back(d);
    fcount = fcount + 1;
    qa.push_back(e);
  endtask

  task automatic get_frame(input int sel, input int nbits, output logic [19:0] bits,
                           output int stab_bad, output int fd_bad, output bit aborted);
    logic s, fd;
    bits = '0; stab_bad = 0; fd_bad = 0; aborted = 0;
    for (int k = 0; k < nbits * BC; k++) begin
      if (k != 0) @(negedge clk);
      if (!rstn) begin
        aborted = 1;
        return;
      end
      s  = (sel != 0) ? sout_b : sout_a;
      fd = (sel != 0) ? frame_done_b : frame_done_a;
      if (k % BC == 0) bits[k / BC] = s;
      else if (bits[k / BC] !== s) stab_bad++;
      if (fd !== (k == nbits * BC - 1)) fd_bad++;
    end
  endtask

  initial begin : mon_a
    exp_t e;
    logic [19:0] b;
    int sb, fb, gap;
    bit ab, have_prev;
    gap = 0; have_prev = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        have_prev = 0; gap = 0;
      end else if (sout_a) begin
        gap++;
      end else begin
        get_frame(0, 19, b, sb, fb, ab);
        if (ab) begin
          have_prev = 0; gap = 0;
        end else begin
          if (qa.size() == 0) begin
            chk("a_unexpected_frame", 1, 0);
          end else begin
            e = qa.pop_front();
            chk("a_start", b[0], 0);
            chk("a_data", b[16:1], e.d);
            chk("a_parity", b[17], e.p);
            chk("a_stop", b[18], 1);
            chk("a_bit_hold", sb, 0);
            chk("a_frame_done", fb, 0);
            if (e.gap >= 0 && have_prev) chk("a_gap", gap, e.gap);
          end
          exp_wc_a = exp_wc_a + 16'd1;
          @(negedge clk);
          chk("a_word_count", word_count_a, exp_wc_a);
          gap = sout_a ? 1 : 0;
          have_prev = 1;
        end
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    logic [19:0] b;
    int sb, fb;
    bit ab;
    forever begin
      @(negedge clk);
      if (rstn && !sout_b) begin
        get_frame(1, 18, b, sb, fb, ab);
        if (!ab) begin
          if (qb.size() == 0) begin
            chk("b_unexpected_frame", 1, 0);
          end else begin
            e = qb.pop_front();
            chk("b_start", b[0], 0);
            chk("b_data", b[16:1], e.d);
            chk("b_stop", b[17], 1);
            chk("b_bit_hold", sb, 0);
            chk("b_frame_done", fb, 0);
          end
          @(negedge clk);
          chk("b_word_count", word_count_b, 1);
        end
      end
    end
  end

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy_a && !busy_b && qa.size() == 0 && qb.size() == 0) begin
        repeat (3) @(negedge clk);
        return;
      end
    end
    chk("timeout_idle", 1, 0);
  endtask

  task automatic wait_sout_low(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!sout_a) return;
    end
    chk("timeout_sout_low", 1, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int rp0;
    bit bad;
    bit seen;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_sout", sout_a, 1);
    chk("rst_readp", readp_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_frame_done", frame_done_a, 0);
    chk("rst_word_count", word_count_a, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // single word with pop/load latency
    enable_a = 1'b1;
    rp0 = rp_a;
    push_a(16'hA5C3, 1'b0, -1);
    @(negedge clk);
    chk("lat_pop_readp", readp_a, 1);
    @(negedge clk);
    chk("lat_load_readp", readp_a, 0);
    chk("lat_load_sout", sout_a, 1);
    chk("lat_load_busy", busy_a, 1);
    @(negedge clk);
    chk("lat_start_sout", sout_a, 0);
    wait_idle(200);
    chk("single_readp_pulses", rp_a - rp0, 1);

    // odd parity data
    push_a(16'h0001, 1'b1, -1);
    wait_idle(200);

    // back-to-back
    rp0 = rp_a;
    push_a(16'h1111, 1'b0, -1);
    push_a(16'h2222, 1'b0, 2);
    push_a(16'h3333, 1'b0, 2);
    wait_idle(600);
    chk("b2b_readp_pulses", rp_a - rp0, 3);
    chk("b2b_busy_after", busy_a, 0);
    chk("b2b_word_count", word_count_a, 5);

    // enable dropped during the first of two queued frames
    rp0 = rp_a;
    push_a(16'h1111, 1'b0, -1);
    push_a(16'h2222, 1'b0, -1);
    wait_sout_low(20);
    enable_a = 1'b0;
    repeat (60) @(negedge clk);
    chk("endrop_readp_pulses", rp_a - rp0, 1);
    chk("endrop_busy", busy_a, 0);
    chk("endrop_fifo_left", fcount, 1);
    enable_a = 1'b1;
    wait_idle(200);
    chk("endrop_readp_total", rp_a - rp0, 2);

    // asynchronous reset in the middle of DATA
    push_a(16'hA5C3, 1'b0, -1);
    wait_sout_low(20);
    repeat (10) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_sout", sout_a, 1);
    chk("midrst_readp", readp_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_word_count", word_count_a, 0);
    qa.delete();
    fq.delete();
    fcount = 0;
    exp_wc_a = 16'd0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rp0 = rp_a;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (readp_a || busy_a) bad = 1;
    end
    chk("postrst_stays_idle", bad, 0);
    chk("postrst_no_readp", rp_a - rp0, 0);

    // word_count wrap
    @(negedge clk);
    force dut_a.word_count_q = 16'hFFFE;
    exp_wc_a = 16'hFFFE;
    @(negedge clk);
    release dut_a.word_count_q;
    push_a(16'h8000, 1'b1, -1);
    push_a(16'h7FFF, 1'b1, 2);
    wait_idle(400);
    chk("wrap_word_count", word_count_a, 0);

    // no-parity instance, one word
    emptyp_b = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (readp_b) seen = 1;
    end
    emptyp_b = 1'b1;
    chk("b_readp_seen", seen, 1);
    if (seen) begin
      qb.push_back('{d: 16'h0001, p: 1'b0, gap: -1});
      wait_idle(200);
    end
    chk("b_idle_after", busy_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
